// File: rtl/fetch_pkg.sv
// Shared widths and helpers for the instruction-fetch stage.
package fetch_pkg;

   localparam int INSTR_W            = 16;
   localparam int ADDR_W             = 32;
   localparam int DEFAULT_MEM_ADDR_W = 12;

   // Sequential fetch only: the next PC is always the current one plus one,
   // wrapping naturally at the top of the 32-bit range.
   function automatic logic [ADDR_W-1:0] nextPc(input logic [ADDR_W-1:0] pc);
      return pc + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_instruction_module_instruction_memory.sv
// Word-addressed instruction memory: one synchronous write port and one
// registered read port. A read and a write to the same word on the same edge
// return the old word.
module instruction_memory
   import fetch_pkg::*;
#(
   parameter int DEPTH_W = DEFAULT_MEM_ADDR_W
) (
   input  logic               i_clk,
   input  logic               i_clearRead,
   input  logic               i_writeEnable,
   input  logic [DEPTH_W-1:0] i_writeAddr,
   input  logic [INSTR_W-1:0] i_writeData,
   input  logic [DEPTH_W-1:0] i_readAddr,
   output logic [INSTR_W-1:0] o_readData
);

   localparam int DEPTH = 2 ** DEPTH_W;

   logic [INSTR_W-1:0] r_mem [DEPTH];
   logic [INSTR_W-1:0] r_readData;

   // Store the incoming word. Reset deliberately has no effect here so the
   // program can be preloaded while the pipeline is held in reset.
   always_ff @(posedge i_clk) begin
      if (i_writeEnable) begin
         r_mem[i_writeAddr] <= i_writeData;
      end
   end

   // Registered read; sampling r_mem in the same edge as the write yields the
   // pre-write contents, giving read-before-write on a collision.
   always_ff @(posedge i_clk) begin
      if (i_clearRead) begin
         r_readData <= '0;
      end else begin
         r_readData <= r_mem[i_readAddr];
      end
   end

   assign o_readData = r_readData;

endmodule

// File: rtl/fetch_instruction_module.sv
// Instruction-fetch stage: internal program counter plus instruction memory,
// presenting one registered instruction per clock to decode.
module fetch_instruction_module
   import fetch_pkg::*;
#(
   parameter int                MEM_ADDR_W = DEFAULT_MEM_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic               write_enable,
   output logic [INSTR_W-1:0] Instruction,
   input  logic [INSTR_W-1:0] write_data,
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  write_addr
);

   logic [ADDR_W-1:0]  r_programCounter;
   logic               w_writeEnable;
   logic [INSTR_W-1:0] w_readData;
   logic [2*(ADDR_W-MEM_ADDR_W)-1:0] w_unusedAddrBits;

   // A floating or unknown strobe must never store a word.
   assign w_writeEnable = (write_enable === 1'b1);

   // Upper address bits are intentionally dropped so addresses alias modulo
   // the memory depth.
   assign w_unusedAddrBits = {write_addr[ADDR_W-1:MEM_ADDR_W],
                              r_programCounter[ADDR_W-1:MEM_ADDR_W]};

   // Program counter: restart on reset, otherwise advance by one every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_programCounter <= RESET_PC;
      end else begin
         r_programCounter <= nextPc(r_programCounter);
      end
   end

   instruction_memory #(
      .DEPTH_W (MEM_ADDR_W)
   ) u_instructionMemory (
      .i_clk         (clk),
      .i_clearRead   (rst),
      .i_writeEnable (w_writeEnable),
      .i_writeAddr   (write_addr[MEM_ADDR_W-1:0]),
      .i_writeData   (write_data),
      .i_readAddr    (r_programCounter[MEM_ADDR_W-1:0]),
      .o_readData    (w_readData)
   );

   assign Instruction = w_readData;

endmodule

// File: tb/tb_fetch_instruction_module.sv
// Directed bench for the fetch stage: reset, preload, fetch order, disabled
// writes, read/write collision, address aliasing, mid-run reset and PC wrap.
module tb_fetch_instruction_module;

   logic        clk;
   logic        rst;
   logic        writeEnable;
   logic [15:0] writeData;
   logic [31:0] writeAddr;
   logic [15:0] instruction;
   logic [15:0] instructionWrap;

   int vectorCount;
   int miscompareCount;

   fetch_instruction_module #(
      .MEM_ADDR_W (12),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .write_enable (writeEnable),
      .Instruction  (instruction),
      .write_data   (writeData),
      .clk          (clk),
      .rst          (rst),
      .write_addr   (writeAddr)
   );

   // Small second instance starting near the top of the PC range.
   fetch_instruction_module #(
      .MEM_ADDR_W (4),
      .RESET_PC   (32'hFFFF_FFFE)
   ) dutWrap (
      .write_enable (writeEnable),
      .Instruction  (instructionWrap),
      .write_data   (writeData),
      .clk          (clk),
      .rst          (rst),
      .write_addr   (writeAddr)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's inputs at a falling edge and return at the next
   // falling edge, so the rising edge in between samples them.
   task automatic applyStimulus(input logic rstV, input logic weV,
                                input logic [31:0] addrV, input logic [15:0] dataV);
      rst         = rstV;
      writeEnable = weV;
      writeAddr   = addrV;
      writeData   = dataV;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Main directed sequence.
   initial begin
      vectorCount     = 0;
      miscompareCount = 0;
      rst         = 1'b1;
      writeEnable = 1'b0;
      writeAddr   = '0;
      writeData   = '0;

      applyStimulus(1'b1, 1'b0, 32'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 16'h0);
      checkOutput("resetInstr", {16'h0, instruction}, 32'h0);
      checkOutput("resetPc", dut.r_programCounter, 32'h0);
      checkOutput("wrapResetPc", dutWrap.r_programCounter, 32'hFFFF_FFFE);

      // Preload under reset.
      applyStimulus(1'b1, 1'b1, 32'h0000, 16'h1111);
      applyStimulus(1'b1, 1'b1, 32'h0001, 16'h2222);
      applyStimulus(1'b1, 1'b1, 32'h0002, 16'h3333);
      applyStimulus(1'b1, 1'b1, 32'h0026, 16'h0C26);
      applyStimulus(1'b1, 1'b1, 32'h0009, 16'h0909);
      checkOutput("instrHeldInReset", {16'h0, instruction}, 32'h0);
      checkOutput("pcHeldInReset", dut.r_programCounter, 32'h0);

      // Release reset while loading 0x70..0x75 into 0x20..0x25.
      for (int e = 1; e <= 6; e++) begin
         applyStimulus(1'b0, 1'b1, 32'h1F + e, 16'(16'h6F + e));
         case (e)
            1: begin
               checkOutput("firstFetch", {16'h0, instruction}, 32'h1111);
               checkOutput("firstPc", dut.r_programCounter, 32'h1);
               checkOutput("wrapPcTop", dutWrap.r_programCounter, 32'hFFFF_FFFF);
            end
            2: begin
               checkOutput("secondFetch", {16'h0, instruction}, 32'h2222);
               checkOutput("wrapPcZero", dutWrap.r_programCounter, 32'h0);
            end
            3: begin
               checkOutput("thirdFetch", {16'h0, instruction}, 32'h3333);
               checkOutput("wrapAliasFetch", {16'h0, instructionWrap}, 32'h0070);
            end
            default: ;
         endcase
      end

      // Edge 7/8: disabled and unknown strobes must not store 0xBEEF.
      applyStimulus(1'b0, 1'b0, 32'h0026, 16'hBEEF);
      applyStimulus(1'b0, 1'bx, 32'h0026, 16'hBEEF);
      // Edge 9: aliased write lands on word 0.
      applyStimulus(1'b0, 1'b1, 32'h1000, 16'hA5A5);
      // Edge 10: PC is 9, write word 9 on the same edge.
      applyStimulus(1'b0, 1'b1, 32'h0009, 16'h1234);
      checkOutput("collisionOld", {16'h0, instruction}, 32'h0909);
      checkOutput("collisionPc", dut.r_programCounter, 32'hA);

      for (int e = 11; e <= 16; e++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 16'h0);
      end
      checkOutput("pcBeforeMidReset", dut.r_programCounter, 32'h10);

      applyStimulus(1'b1, 1'b0, 32'h0, 16'h0);
      checkOutput("midResetInstr", {16'h0, instruction}, 32'h0);
      checkOutput("midResetPc", dut.r_programCounter, 32'h0);

      // Refetch from word 0 after the mid-run reset.
      for (int e = 1; e <= 39; e++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 16'h0);
         if (e == 1) begin
            checkOutput("aliasFetch", {16'h0, instruction}, 32'hA5A5);
         end else if (e == 2) begin
            checkOutput("refetchWord1", {16'h0, instruction}, 32'h2222);
         end else if (e == 10) begin
            checkOutput("collisionNew", {16'h0, instruction}, 32'h1234);
         end else if (e >= 33 && e <= 38) begin
            checkOutput($sformatf("loadFetch%0d", e), {16'h0, instruction},
                        32'h70 + 32'(e - 33));
         end else if (e == 39) begin
            checkOutput("writeDisabled", {16'h0, instruction}, 32'h0C26);
            checkOutput("pcAfterRefetch", dut.r_programCounter, 32'd39);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
